// File: rtl/id_ex_stage.sv
// id_ex_stage: MIPS-subset decode, N-source operand forwarding, load-use interlock and a
// registered ID/EX latch with valid/ready handshake. Define ID_ILLEGAL_TRAP_EN to flag reserved instructions.
module id_ex_stage #(
   parameter int DATA_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int FWD_STAGES = 2
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             in_valid,
   output logic                             in_ready,
   input  logic [DATA_W-1:0]                pc_i,
   input  logic [31:0]                      inst_i,
   output logic                             reg1_read_o,
   output logic                             reg2_read_o,
   output logic [REG_ADDR_W-1:0]            reg1_addr_o,
   output logic [REG_ADDR_W-1:0]            reg2_addr_o,
   input  logic [DATA_W-1:0]                reg1_data_i,
   input  logic [DATA_W-1:0]                reg2_data_i,
   input  logic [FWD_STAGES-1:0]            fwd_wreg_i,
   input  logic [FWD_STAGES*REG_ADDR_W-1:0] fwd_wd_i,
   input  logic [FWD_STAGES*DATA_W-1:0]     fwd_wdata_i,
   input  logic                             ex_is_load_i,
   input  logic                             flush_i,
   output logic                             stallreq_o,
   output logic                             out_valid,
   input  logic                             out_ready,
   output logic [7:0]                       aluop_o,
   output logic [2:0]                       alusel_o,
   output logic [DATA_W-1:0]                reg1_o,
   output logic [DATA_W-1:0]                reg2_o,
   output logic [REG_ADDR_W-1:0]            wd_o,
   output logic                             wreg_o,
   output logic [DATA_W-1:0]                pc_o,
   output logic                             inst_invalid_o
);
   localparam logic [5:0] OP_SPECIAL = 6'b000000, OP_ANDI = 6'b001100, OP_ORI = 6'b001101;
   localparam logic [5:0] OP_XORI = 6'b001110, OP_ADDIU = 6'b001001, OP_LUI = 6'b001111;
   localparam logic [5:0] FN_SLL = 6'b000000, FN_ADDU = 6'b100001, FN_SUBU = 6'b100011;
   localparam logic [5:0] FN_AND = 6'b100100, FN_OR = 6'b100101, FN_XOR = 6'b100110, FN_NOR = 6'b100111;
   localparam logic [7:0] EXE_NOP_OP = 8'b00000000, EXE_AND_OP = 8'b00100100, EXE_OR_OP = 8'b00100101;
   localparam logic [7:0] EXE_XOR_OP = 8'b00100110, EXE_NOR_OP = 8'b00100111, EXE_ADDU_OP = 8'b00100001;
   localparam logic [7:0] EXE_SUBU_OP = 8'b00100011, EXE_ADDIU_OP = 8'b01010110, EXE_SLL_OP = 8'b01111100;
   localparam logic [2:0] EXE_RES_NOP = 3'b000, EXE_RES_LOGIC = 3'b001, EXE_RES_SHIFT = 3'b010;
   localparam logic [2:0] EXE_RES_ARITHMETIC = 3'b100;
`ifdef ID_ILLEGAL_TRAP_EN
   localparam logic TRAP_EN = 1'b1;
`else
   localparam logic TRAP_EN = 1'b0;
`endif

   logic [5:0]            op, funct;
   logic [REG_ADDR_W-1:0] rs, rt, rd;
   logic                  dec_r1_en, dec_r2_en, dec_wreg, dec_invalid;
   logic [REG_ADDR_W-1:0] dec_wd;
   logic [7:0]            dec_aluop;
   logic [2:0]            dec_alusel;
   logic [DATA_W-1:0]     dec_imm1, dec_imm2, opnd1, opnd2;
   logic                  hazard1, hazard2, capture;

   logic                  out_valid_d, out_valid_q, wreg_d, wreg_q, inst_invalid_d, inst_invalid_q;
   logic [7:0]            aluop_d, aluop_q;
   logic [2:0]            alusel_d, alusel_q;
   logic [DATA_W-1:0]     reg1_d, reg1_q, reg2_d, reg2_q, pc_d, pc_q;
   logic [REG_ADDR_W-1:0] wd_d, wd_q;

   assign op    = inst_i[31:26];
   assign funct = inst_i[5:0];
   assign rs    = REG_ADDR_W'(inst_i[25:21]);
   assign rt    = REG_ADDR_W'(inst_i[20:16]);
   assign rd    = REG_ADDR_W'(inst_i[15:11]);

   always_comb begin
      dec_r1_en   = 1'b0;
      dec_r2_en   = 1'b0;
      dec_wreg    = 1'b0;
      dec_invalid = 1'b1;
      dec_wd      = '0;
      dec_aluop   = EXE_NOP_OP;
      dec_alusel  = EXE_RES_NOP;
      dec_imm1    = '0;
      dec_imm2    = '0;
      case (op)
         OP_ORI, OP_ANDI, OP_XORI: begin
            dec_r1_en   = 1'b1;
            dec_imm2    = DATA_W'(inst_i[15:0]);
            dec_wd      = rt;
            dec_wreg    = 1'b1;
            dec_invalid = 1'b0;
            dec_alusel  = EXE_RES_LOGIC;
            dec_aluop   = (op == OP_ORI) ? EXE_OR_OP : ((op == OP_ANDI) ? EXE_AND_OP : EXE_XOR_OP);
         end
         OP_ADDIU: begin
            dec_r1_en   = 1'b1;
            dec_imm2    = DATA_W'($signed(inst_i[15:0]));
            dec_wd      = rt;
            dec_wreg    = 1'b1;
            dec_invalid = 1'b0;
            dec_alusel  = EXE_RES_ARITHMETIC;
            dec_aluop   = EXE_ADDIU_OP;
         end
         OP_LUI: begin
            // Both operands carry the shifted immediate so the OR in EX reproduces it.
            dec_imm1    = DATA_W'({inst_i[15:0], 16'h0000});
            dec_imm2    = DATA_W'({inst_i[15:0], 16'h0000});
            dec_wd      = rt;
            dec_wreg    = 1'b1;
            dec_invalid = 1'b0;
            dec_alusel  = EXE_RES_LOGIC;
            dec_aluop   = EXE_OR_OP;
         end
         OP_SPECIAL: begin
            case (funct)
               FN_AND, FN_OR, FN_XOR, FN_NOR, FN_ADDU, FN_SUBU: begin
                  dec_r1_en   = 1'b1;
                  dec_r2_en   = 1'b1;
                  dec_wd      = rd;
                  dec_wreg    = 1'b1;
                  dec_invalid = 1'b0;
                  case (funct)
                     FN_AND:  begin dec_aluop = EXE_AND_OP;  dec_alusel = EXE_RES_LOGIC;      end
                     FN_OR:   begin dec_aluop = EXE_OR_OP;   dec_alusel = EXE_RES_LOGIC;      end
                     FN_XOR:  begin dec_aluop = EXE_XOR_OP;  dec_alusel = EXE_RES_LOGIC;      end
                     FN_NOR:  begin dec_aluop = EXE_NOR_OP;  dec_alusel = EXE_RES_LOGIC;      end
                     FN_ADDU: begin dec_aluop = EXE_ADDU_OP; dec_alusel = EXE_RES_ARITHMETIC; end
                     default: begin dec_aluop = EXE_SUBU_OP; dec_alusel = EXE_RES_ARITHMETIC; end
                  endcase
               end
               FN_SLL: begin
                  dec_r2_en   = 1'b1;
                  dec_imm1    = DATA_W'(inst_i[10:6]);
                  dec_wd      = rd;
                  dec_wreg    = 1'b1;
                  dec_invalid = 1'b0;
                  dec_aluop   = EXE_SLL_OP;
                  dec_alusel  = EXE_RES_SHIFT;
               end
               default: ;
            endcase
         end
         default: ;
      endcase
   end

   // Lowest-index (youngest) matching source wins; $0 and immediates bypass forwarding.
   function automatic logic [DATA_W-1:0] sel_operand(
      input logic                             en,
      input logic [REG_ADDR_W-1:0]            addr,
      input logic [DATA_W-1:0]                rf_data,
      input logic [DATA_W-1:0]                imm,
      input logic [FWD_STAGES-1:0]            wreg,
      input logic [FWD_STAGES*REG_ADDR_W-1:0] wd,
      input logic [FWD_STAGES*DATA_W-1:0]     wdata
   );
      logic [DATA_W-1:0] v;
      v = rf_data;
      for (int i = FWD_STAGES - 1; i >= 0; i--) begin
         if (wreg[i] && (wd[i*REG_ADDR_W +: REG_ADDR_W] == addr)) v = wdata[i*DATA_W +: DATA_W];
      end
      if (addr == '0) v = '0;
      if (!en) v = imm;
      return v;
   endfunction

   assign reg1_read_o = in_valid & dec_r1_en;
   assign reg2_read_o = in_valid & dec_r2_en;
   assign reg1_addr_o = reg1_read_o ? rs : '0;
   assign reg2_addr_o = reg2_read_o ? rt : '0;

   assign opnd1 = sel_operand(reg1_read_o, reg1_addr_o, reg1_data_i, dec_imm1, fwd_wreg_i, fwd_wd_i, fwd_wdata_i);
   assign opnd2 = sel_operand(reg2_read_o, reg2_addr_o, reg2_data_i, dec_imm2, fwd_wreg_i, fwd_wd_i, fwd_wdata_i);

   assign hazard1    = reg1_read_o && (reg1_addr_o != '0) && (reg1_addr_o == fwd_wd_i[REG_ADDR_W-1:0]);
   assign hazard2    = reg2_read_o && (reg2_addr_o != '0) && (reg2_addr_o == fwd_wd_i[REG_ADDR_W-1:0]);
   assign stallreq_o = in_valid & ex_is_load_i & fwd_wreg_i[0] & (hazard1 | hazard2);
   assign in_ready   = (~out_valid_q | out_ready) & ~stallreq_o & ~flush_i;
   assign capture    = in_valid & in_ready;

   always_comb begin
      out_valid_d    = out_valid_q;
      aluop_d        = aluop_q;
      alusel_d       = alusel_q;
      reg1_d         = reg1_q;
      reg2_d         = reg2_q;
      wd_d           = wd_q;
      wreg_d         = wreg_q;
      pc_d           = pc_q;
      inst_invalid_d = inst_invalid_q;
      if (flush_i) begin
         out_valid_d = 1'b0;
      end else if (capture) begin
         out_valid_d    = 1'b1;
         aluop_d        = dec_aluop;
         alusel_d       = dec_alusel;
         reg1_d         = opnd1;
         reg2_d         = opnd2;
         wd_d           = dec_wd;
         wreg_d         = dec_wreg;
         pc_d           = pc_i;
         inst_invalid_d = dec_invalid & TRAP_EN;
      end else if (out_valid_q && out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_q    <= 1'b0;
         aluop_q        <= EXE_NOP_OP;
         alusel_q       <= EXE_RES_NOP;
         reg1_q         <= '0;
         reg2_q         <= '0;
         wd_q           <= '0;
         wreg_q         <= 1'b0;
         pc_q           <= '0;
         inst_invalid_q <= 1'b0;
      end else begin
         out_valid_q    <= out_valid_d;
         aluop_q        <= aluop_d;
         alusel_q       <= alusel_d;
         reg1_q         <= reg1_d;
         reg2_q         <= reg2_d;
         wd_q           <= wd_d;
         wreg_q         <= wreg_d;
         pc_q           <= pc_d;
         inst_invalid_q <= inst_invalid_d;
      end
   end

   assign out_valid      = out_valid_q;
   assign aluop_o        = aluop_q;
   assign alusel_o       = alusel_q;
   assign reg1_o         = reg1_q;
   assign reg2_o         = reg2_q;
   assign wd_o           = wd_q;
   assign wreg_o         = wreg_q;
   assign pc_o           = pc_q;
   assign inst_invalid_o = inst_invalid_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: directed plan cases plus randomized traffic against a table-driven
// reference model of decode, forwarding, interlock and the ID/EX latch.
module tb_id_ex_stage;
   logic        clk, rst, in_valid, in_ready, out_valid, out_ready;
   logic [31:0] pc_i, inst_i, reg1_data_i, reg2_data_i;
   logic        reg1_read_o, reg2_read_o, ex_is_load_i, flush_i, stallreq_o;
   logic [4:0]  reg1_addr_o, reg2_addr_o, wd_o;
   logic [1:0]  fwd_wreg_i;
   logic [9:0]  fwd_wd_i;
   logic [63:0] fwd_wdata_i;
   logic [7:0]  aluop_o;
   logic [2:0]  alusel_o;
   logic [31:0] reg1_o, reg2_o, pc_o;
   logic        wreg_o, inst_invalid_o;

   int n_checks = 0;
   int n_errors = 0;

`ifdef ID_ILLEGAL_TRAP_EN
   localparam bit EXP_TRAP = 1'b1;
`else
   localparam bit EXP_TRAP = 1'b0;
`endif

   id_ex_stage #(.DATA_W(32), .REG_ADDR_W(5), .FWD_STAGES(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .pc_i(pc_i), .inst_i(inst_i),
      .reg1_read_o(reg1_read_o), .reg2_read_o(reg2_read_o), .reg1_addr_o(reg1_addr_o),
      .reg2_addr_o(reg2_addr_o), .reg1_data_i(reg1_data_i), .reg2_data_i(reg2_data_i),
      .fwd_wreg_i(fwd_wreg_i), .fwd_wd_i(fwd_wd_i), .fwd_wdata_i(fwd_wdata_i),
      .ex_is_load_i(ex_is_load_i), .flush_i(flush_i), .stallreq_o(stallreq_o),
      .out_valid(out_valid), .out_ready(out_ready), .aluop_o(aluop_o), .alusel_o(alusel_o),
      .reg1_o(reg1_o), .reg2_o(reg2_o), .wd_o(wd_o), .wreg_o(wreg_o), .pc_o(pc_o),
      .inst_invalid_o(inst_invalid_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Instruction table: operand shape per kind.
   localparam bit [2:0] K_ZX = 0, K_SX = 1, K_LUI = 2, K_RR = 3, K_SLL = 4;
   typedef struct packed { bit [5:0] op; bit [5:0] fn; bit [7:0] aluop; bit [2:0] sel; bit [2:0] kind; } ent_t;
   ent_t tbl [12] = '{
      '{6'b001101, 6'd0, 8'h25, 3'b001, K_ZX},   // ori
      '{6'b001100, 6'd0, 8'h24, 3'b001, K_ZX},   // andi
      '{6'b001110, 6'd0, 8'h26, 3'b001, K_ZX},   // xori
      '{6'b001001, 6'd0, 8'h56, 3'b100, K_SX},   // addiu
      '{6'b001111, 6'd0, 8'h25, 3'b001, K_LUI},  // lui
      '{6'b000000, 6'h24, 8'h24, 3'b001, K_RR},  // and
      '{6'b000000, 6'h25, 8'h25, 3'b001, K_RR},  // or
      '{6'b000000, 6'h26, 8'h26, 3'b001, K_RR},  // xor
      '{6'b000000, 6'h27, 8'h27, 3'b001, K_RR},  // nor
      '{6'b000000, 6'h21, 8'h21, 3'b100, K_RR},  // addu
      '{6'b000000, 6'h23, 8'h23, 3'b100, K_RR},  // subu
      '{6'b000000, 6'h00, 8'h7C, 3'b010, K_SLL}  // sll
   };

   typedef struct packed {
      bit ok; bit r1_en; bit r2_en; bit [4:0] a1; bit [4:0] a2; bit [4:0] wd; bit wreg;
      bit [31:0] imm1; bit [31:0] imm2; bit [7:0] aluop; bit [2:0] sel;
   } dec_t;

   function automatic dec_t model_decode(input bit [31:0] ins);
      dec_t d;
      d = '0;
      for (int k = 0; k < 12; k++) begin
         if (!d.ok && ins[31:26] == tbl[k].op && (tbl[k].op != 0 || ins[5:0] == tbl[k].fn)) begin
            d.ok = 1; d.wreg = 1; d.aluop = tbl[k].aluop; d.sel = tbl[k].sel;
            case (tbl[k].kind)
               K_ZX:  begin d.r1_en = 1; d.a1 = ins[25:21]; d.imm2 = {16'h0, ins[15:0]}; d.wd = ins[20:16]; end
               K_SX:  begin d.r1_en = 1; d.a1 = ins[25:21]; d.imm2 = {{16{ins[15]}}, ins[15:0]}; d.wd = ins[20:16]; end
               K_LUI: begin d.imm1 = {ins[15:0], 16'h0}; d.imm2 = {ins[15:0], 16'h0}; d.wd = ins[20:16]; end
               K_RR:  begin d.r1_en = 1; d.r2_en = 1; d.a1 = ins[25:21]; d.a2 = ins[20:16]; d.wd = ins[15:11]; end
               default: begin d.r2_en = 1; d.a2 = ins[20:16]; d.imm1 = {27'h0, ins[10:6]}; d.wd = ins[15:11]; end
            endcase
         end
      end
      return d;
   endfunction

   function automatic bit [31:0] model_operand(input bit en, input bit [4:0] a, input bit [31:0] rf, input bit [31:0] imm);
      if (!en) return imm;
      if (a == 0) return 32'h0;
      for (int i = 0; i < 2; i++)
         if (fwd_wreg_i[i] && fwd_wd_i[i*5 +: 5] == a) return fwd_wdata_i[i*32 +: 32];
      return rf;
   endfunction

   bit        m_valid, m_wreg, m_inv, m_known;
   bit [7:0]  m_aluop;
   bit [2:0]  m_sel;
   bit [31:0] m_r1, m_r2, m_pc;
   bit [4:0]  m_wd;

   task automatic model_reset();
      m_valid = 0; m_wreg = 0; m_inv = 0; m_known = 1; m_aluop = 0; m_sel = 0;
      m_r1 = 0; m_r2 = 0; m_pc = 0; m_wd = 0;
   endtask

   // Checks one cycle at negedge+1 then advances the model across the posedge.
   task automatic cycle();
      dec_t d;
      bit   e1, e2, h1, h2, e_stall, e_rdy, cap;
      bit [31:0] o1, o2;
      #1;
      d  = model_decode(inst_i);
      e1 = in_valid && d.r1_en;
      e2 = in_valid && d.r2_en;
      h1 = e1 && d.a1 != 0 && d.a1 == fwd_wd_i[4:0];
      h2 = e2 && d.a2 != 0 && d.a2 == fwd_wd_i[4:0];
      e_stall = in_valid && ex_is_load_i && fwd_wreg_i[0] && (h1 || h2);
      e_rdy   = (!m_valid || out_ready) && !e_stall && !flush_i;
      o1 = model_operand(e1, d.a1, reg1_data_i, d.imm1);
      o2 = model_operand(e2, d.a2, reg2_data_i, d.imm2);
      check("stallreq", stallreq_o, e_stall);
      check("in_ready", in_ready, e_rdy);
      check("rd1_en", reg1_read_o, e1);
      check("rd2_en", reg2_read_o, e2);
      check("rd1_addr", reg1_addr_o, e1 ? d.a1 : 5'd0);
      check("rd2_addr", reg2_addr_o, e2 ? d.a2 : 5'd0);
      check("out_valid", out_valid, m_valid);
      check("aluop", aluop_o, m_aluop);
      check("alusel", alusel_o, m_sel);
      check("wreg", wreg_o, m_wreg);
      check("pc", pc_o, m_pc);
      check("invalid", inst_invalid_o, m_inv);
      if (m_known) begin
         check("reg1", reg1_o, m_r1);
         check("reg2", reg2_o, m_r2);
         check("wd", wd_o, m_wd);
      end
      cap = in_valid && e_rdy;
      @(posedge clk);
      if (rst) model_reset();
      else if (flush_i) m_valid = 0;
      else if (cap) begin
         m_valid = 1; m_pc = pc_i; m_known = d.ok; m_inv = !d.ok && EXP_TRAP;
         m_aluop = d.aluop; m_sel = d.sel; m_wreg = d.wreg; m_wd = d.wd; m_r1 = o1; m_r2 = o2;
      end else if (m_valid && out_ready) m_valid = 0;
      @(negedge clk);
   endtask

   function automatic bit [31:0] rand_inst();
      int k;
      bit [4:0] rs, rt, rd;
      k  = $urandom_range(0, 13);
      rs = 5'($urandom_range(0, 7));
      rt = 5'($urandom_range(0, 7));
      rd = 5'($urandom_range(0, 7));
      if (k == 12) return ($urandom_range(0, 1) == 1) ? 32'hFC000000 : {6'b100011, 26'($urandom)};
      if (k == 13) return {6'd0, 20'($urandom), 6'b001000};
      if (tbl[k].op != 0) return {tbl[k].op, rs, rt, 16'($urandom)};
      return {6'd0, rs, rt, rd, 5'($urandom), tbl[k].fn};
   endfunction

   initial begin
      rst = 1; in_valid = 0; out_ready = 1; pc_i = 0; inst_i = 0; reg1_data_i = 0; reg2_data_i = 0;
      fwd_wreg_i = 0; fwd_wd_i = 0; fwd_wdata_i = 0; ex_is_load_i = 0; flush_i = 0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 0;
      model_reset();
      check("rst_valid", out_valid, 0);
      check("rst_aluop", aluop_o, 0);
      check("rst_reg2", reg2_o, 0);

      // ORI $1,$0,0x1100
      in_valid = 1; pc_i = 32'h100; inst_i = 32'h34011100;
      cycle();
      check("ori_valid", out_valid, 1);
      check("ori_reg2", reg2_o, 32'h00001100);
      check("ori_wd", wd_o, 1);
      check("ori_aluop", aluop_o, 8'h25);

      // OR $3,$1,$2 with both sources writing $1: EX wins
      inst_i = 32'h00221825; pc_i = 32'h104; reg2_data_i = 32'h0000BBBB; reg1_data_i = 32'hDEAD0001;
      fwd_wreg_i = 2'b11; fwd_wd_i = {5'd1, 5'd1}; fwd_wdata_i = {32'h11111111, 32'hAAAA0000};
      cycle();
      check("fwd_ex_wins", reg1_o, 32'hAAAA0000);
      check("fwd_rf_reg2", reg2_o, 32'h0000BBBB);

      // ADDIU $4,$0,0xFFFF: no forwarding to $0
      inst_i = 32'h2404FFFF; fwd_wreg_i = 2'b01; fwd_wd_i = 10'd0; fwd_wdata_i = {32'h0, 32'h12345678};
      cycle();
      check("zero_reg1", reg1_o, 32'h0);
      check("sext_reg2", reg2_o, 32'hFFFFFFFF);

      // OR $5,$6,$0 behind a load writing $6
      inst_i = 32'h00C02825; ex_is_load_i = 1; fwd_wreg_i = 2'b01; fwd_wd_i = {5'd0, 5'd6};
      fwd_wdata_i = {32'h0, 32'h600D0006};
      #1;
      check("lu_stall", stallreq_o, 1);
      check("lu_ready", in_ready, 0);
      cycle();
      check("lu_bubble", out_valid, 0);
      ex_is_load_i = 0;
      cycle();
      check("lu_capture", out_valid, 1);
      check("lu_fwd", reg1_o, 32'h600D0006);

      // Backpressure for 3 cycles, then flush, then reset during a stall
      inst_i = 32'h344700F0; out_ready = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         check("bp_hold_valid", out_valid, 1);
         check("bp_hold_reg1", reg1_o, 32'h600D0006);
      end
      flush_i = 1;
      cycle();
      flush_i = 0;
      check("flush_valid", out_valid, 0);
      check("flush_no_cap", wd_o, 5);
      out_ready = 1;
      cycle();
      check("after_flush_cap", wd_o, 7);
      inst_i = 32'h00C02825; ex_is_load_i = 1; rst = 1;
      cycle();
      rst = 0; ex_is_load_i = 0; in_valid = 0;
      check("midrst_valid", out_valid, 0);
      check("midrst_reg1", reg1_o, 0);
      check("midrst_pc", pc_o, 0);
      cycle();

      // Reserved instruction
      in_valid = 1; inst_i = 32'hFC000000; pc_i = 32'h200;
      cycle();
      check("ill_valid", out_valid, 1);
      check("ill_flag", inst_invalid_o, EXP_TRAP);
      check("ill_wreg", wreg_o, 0);
      check("ill_aluop", aluop_o, 0);

      for (int n = 0; n < 3000; n++) begin
         rst          = ($urandom_range(0, 99) == 0);
         flush_i      = ($urandom_range(0, 19) == 0);
         in_valid     = ($urandom_range(0, 4) != 0);
         out_ready    = ($urandom_range(0, 3) != 0);
         ex_is_load_i = ($urandom_range(0, 2) == 0);
         inst_i       = rand_inst();
         pc_i         = $urandom;
         reg1_data_i  = $urandom;
         reg2_data_i  = $urandom;
         fwd_wreg_i   = 2'($urandom);
         fwd_wd_i     = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
         fwd_wdata_i  = {32'($urandom), 32'($urandom)};
         cycle();
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- Parametrised successor to the combinational decode stage: decode, operand selection with N-source forwarding, load-use interlock, and a registered ID/EX pipeline latch with valid/ready handshake.
- Sits between the IF/ID latch and the EX stage.
- Replaces the combinational decoder and the separate id_ex register.
- Forwarding sources are indexed youngest-first: index 0 is EX, index 1 is MEM, and so on.

Parameters:
- DATA_W, 32, register/operand width.
- REG_ADDR_W, 5, register address width.
- FWD_STAGES, 2, number of forwarding sources (index 0 = EX).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high (`RstEnable).
- in_valid  in  1  IF/ID holds a valid instruction.
- in_ready  out  1  stage accepts the instruction this cycle.
- pc_i  in  DATA_W  instruction PC.
- inst_i  in  32  instruction word.
- reg1_read_o, reg2_read_o  out  1  regfile read enables (combinational).
- reg1_addr_o, reg2_addr_o  out  REG_ADDR_W  regfile read addresses (combinational).
- reg1_data_i, reg2_data_i  in  DATA_W  regfile read data.
- fwd_wreg_i  in  FWD_STAGES  per-source write enable.
- fwd_wd_i  in  FWD_STAGES*REG_ADDR_W  per-source destination register.
- fwd_wdata_i  in  FWD_STAGES*DATA_W  per-source result.
- ex_is_load_i  in  1  instruction in EX is a load; its data is not yet valid.
- flush_i  in  1  kill the latched and incoming instruction.
- stallreq_o  out  1  load-use stall request (combinational).
- out_valid  out  1  ID/EX latch valid.
- out_ready  in  1  EX accepts the latch contents.
- aluop_o  out  8  `EXE_*_OP code.
- alusel_o  out  3  `EXE_RES_* code.
- reg1_o, reg2_o  out  DATA_W  operands.
- wd_o  out  REG_ADDR_W  destination register.
- wreg_o  out  1  write-back enable.
- pc_o  out  DATA_W  PC passthrough.
- inst_invalid_o  out  1  reserved-instruction flag.

Behaviour:
- Decode (combinational):
  - ORI, ANDI, XORI: rs read, zero-extended imm16, wd = rt.
  - ADDIU: rs read, sign-extended imm16, wd = rt.
  - LUI: no register read, imm = {imm16, 16'h0}, wd = rt.
  - SPECIAL (op = 0) with funct AND, OR, XOR, NOR, ADDU, SUBU: rs and rt read, wd = rd.
  - SPECIAL SLL (funct 0): rt read; reg1 = zero-extended sa (inst[10:6]); wd = rd.
  - Anything else: NOP, wreg = 0, invalid = 1.
- Operand selection, per port, when its read enable is 1:
  - Address 0 always yields 0 and is never forwarded.
  - Otherwise use the lowest-index source with fwd_wreg = 1 and fwd_wd equal to the read address.
  - If no source matches, use the regfile data (reg1_data_i for port 1, reg2_data_i for port 2).
  - Read enable 0: the operand is imm. SLL reg1 is sa as defined above.
- Interlock:
  - stallreq_o = in_valid & ex_is_load_i & fwd_wreg_i[0] & (some enabled read port has a non-zero address equal to fwd_wd_i[0]).
- Handshake:
  - in_ready = (!out_valid | out_ready) & !stallreq_o & !flush_i.
  - Capture happens when in_valid & in_ready; the latch loads the decoded fields and out_valid becomes 1 next cycle.
  - If out_valid & out_ready and no capture, out_valid becomes 0.
  - Latch contents hold while out_valid & !out_ready (backpressure).
  - Stall with out_ready = 1: the latch drains, out_valid = 0 (bubble), and the instruction stays in IF/ID.
- flush_i: highest priority below rst. out_valid becomes 0 next cycle and no capture happens that cycle.
- Reset (synchronous):
  - out_valid = 0, aluop_o = `EXE_NOP_OP, alusel_o = `EXE_RES_NOP.
  - reg1_o = reg2_o = 0, wd_o = 0, wreg_o = 0, pc_o = 0, inst_invalid_o = 0.
  - Reset mid-stall discards everything.
- Latency: one cycle from capture to out_valid.
- Read enables and addresses are driven 0 when in_valid = 0.

Optional Feature:
- ID_ILLEGAL_TRAP_EN defined:
  - An undecodable instruction is captured with inst_invalid_o = 1, wreg_o = 0 and NOP op/sel.
  - The flag travels with out_valid so a later stage can raise the reserved-instruction exception.
- ID_ILLEGAL_TRAP_EN undefined:
  - inst_invalid_o is tied to 0.
  - An undecodable instruction passes as a plain NOP.

Test Plan:
- ORI $1,$0,0x1100 with in_valid = 1, out_ready = 1 -> next cycle out_valid = 1, reg1_o = 0, reg2_o = 0x00001100, wd_o = 1, wreg_o = 1, aluop_o = `EXE_OR_OP.
- OR $3,$1,$2; fwd[0] = {wreg 1, wd 1, 0xAAAA0000}; fwd[1] = {wreg 1, wd 1, 0x11111111}; reg2_data_i = 0x0000BBBB -> reg1_o = 0xAAAA0000 (EX wins), reg2_o = 0x0000BBBB.
- ADDIU $4,$0,0xFFFF with fwd[0] = {wreg 1, wd 0, 0x12345678} -> reg1_o = 0 (no forwarding to $0), reg2_o = 0xFFFFFFFF.
- OR $5,$6,$0 with ex_is_load_i = 1, fwd[0] = {wreg 1, wd 6} -> stallreq_o = 1 and in_ready = 0; one bubble (out_valid = 0); release ex_is_load_i -> captured next cycle.
- out_ready = 0 for 3 cycles with out_valid = 1 -> latch holds its values and in_ready = 0; then flush_i = 1 for one cycle -> out_valid = 0 and no capture; rst mid-sequence -> every output at its reset value.
- Instruction 0xFC000000: with ID_ILLEGAL_TRAP_EN defined -> inst_invalid_o = 1, wreg_o = 0; without the macro -> inst_invalid_o = 0 and a NOP result.
